vram_port_arbiter: RTL and testbench

Single-clock arbiter that shares the text controller's single-port VRAM block RAM (600 character words plus the control register, 601 words total) between two requesters. The requesters are the AXI4-Lite slave logic (the host port) and the video glyph-fetch logic (the video port). Video is favoured so scan-out never stalls, and a starvation counter guarantees the host a slot within a bounded number of cycles. The block sits between the AXI register interface, the color-mapper fetch path and the BRAM.

---
 rtl/vram_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares the text controller's single-port VRAM (character words plus the
// control register) between the AXI4-Lite host logic and the video
// glyph-fetch logic. Video wins any contested slot so scan-out never stalls.
// A saturating starvation counter forces a host slot once the host has been
// denied STARVE_MAX cycles in a row.
//
// Ports
//   axi_aclk, axi_aresetn   clock, synchronous active-low reset
//   host_req/we/addr/wdata/wstrb
//                           four-phase host request (held until ack is seen)
//   host_ack/rdata/err      one-cycle completion pulse; rdata/err valid with it
//   vid_req/addr            single-cycle video fetch request
//   vid_gnt                 combinational grant in the request cycle
//   vid_rvalid/rdata        fetched word, one cycle after vid_gnt
//   mem_en/we/addr/wdata    BRAM port (driven in the grant cycle)
//   mem_rdata               BRAM read data, one-cycle latency
// -----------------------------------------------------------------------------
module vram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int NUM_WORDS  = 601,
    parameter int STARVE_MAX = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [3:0]        host_wstrb,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(STARVE_MAX);
    // One extra bit so NUM_WORDS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } state_e;

    // Who used the BRAM slot last cycle; decides where mem_rdata goes.
    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_VID,
        OWN_HOST_RD,
        OWN_HOST_WR,
        OWN_HOST_ERR
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              host_elig;
    logic              host_force;
    logic              host_win;
    logic              vid_win;
    logic              host_in_range;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values of the others, independent of statement order.
        if (!axi_aresetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration and next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        owner_d      = OWN_NONE;
        starve_cnt_d = starve_cnt_q;

        // Grants are held off while reset is asserted so the BRAM port and
        // vid_gnt stay quiet even if requesters keep driving.
        host_in_range = ({1'b0, host_addr} < ADDR_LIMIT);
        host_elig     = axi_aresetn &&
                        (((state_q == ST_IDLE) && host_req) || (state_q == ST_WAIT));
        host_force    = host_elig && (starve_cnt_q == CNT_MAX);
        vid_win       = axi_aresetn && vid_req && !host_force;
        host_win      = host_elig && !vid_win;

        case (state_q)
            ST_IDLE: begin
                if (host_elig) begin
                    state_d = host_win ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (host_win) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = host_req ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!host_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (host_win) begin
            starve_cnt_d = '0;
        end else if (host_elig && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        if (vid_win) begin
            owner_d = OWN_VID;
        end else if (host_win) begin
            if (!host_in_range) begin
                owner_d = OWN_HOST_ERR;
            end else if (host_we) begin
                owner_d = OWN_HOST_WR;
            end else begin
                owner_d = OWN_HOST_RD;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        vid_gnt   = vid_win;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (vid_win) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (host_win && host_in_range) begin
            // An out-of-range host grant consumes the slot but never
            // touches the BRAM.
            mem_en   = 1'b1;
            mem_addr = host_addr;
            if (host_we) begin
                mem_we    = host_wstrb;
                mem_wdata = host_wdata;
            end
        end

        host_ack   = (state_q == ST_ACK);
        host_err   = host_ack && (owner_q == OWN_HOST_ERR);
        host_rdata = (host_ack && (owner_q == OWN_HOST_RD)) ? mem_rdata : '0;
        vid_rvalid = (owner_q == OWN_VID);
        vid_rdata  = vid_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_port_arbiter
//
// Self-checking bench for vram_port_arbiter. A behavioural BRAM with
// one-cycle read latency sits on the memory port; an independent word array
// (ref_mem) holds what the memory should contain from the requesters' point
// of view. Inputs change 1 time unit after the rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vram_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int NUM_WORDS  = 601;
    localparam int STARVE_MAX = 4;
    localparam logic [31:0] CTRL_INIT = 32'h001F_6000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              host_req, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [3:0]        host_wstrb;
    logic              host_ack, host_err;
    logic [DATA_W-1:0] host_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] bram    [NUM_WORDS];
    logic [31:0] ref_mem [NUM_WORDS];

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_wstrb (host_wstrb),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Read-first single-port BRAM with byte enables.
    always @(posedge clk) begin
        if (mem_en && (int'(mem_addr) < NUM_WORDS)) begin
            mem_rdata <= bram[int'(mem_addr)];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) bram[int'(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                 input logic [31:0] new_w,
                                                 input logic [3:0]  st);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete host transaction with no video traffic.
    task automatic host_single(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wd, input logic [3:0] st,
                               input string tag, output logic [31:0] rd);
        logic        in_rng;
        logic [31:0] exp_rd;
        in_rng = int'(addr) < NUM_WORDS;
        exp_rd = 32'h0;
        if (in_rng && !we) exp_rd = ref_mem[int'(addr)];

        host_req = 1'b1; host_we = we; host_addr = addr;
        host_wdata = wd; host_wstrb = st; vid_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({vid_gnt, mem_en, host_ack} !== {1'b0, in_rng, 1'b0}) begin
            errors++;
            $display("FAIL %s_grant: gnt/en/ack=%b%b%b required 0%b0", tag, vid_gnt, mem_en, host_ack, in_rng);
        end
        if (in_rng) begin
            checks++;
            if ({mem_addr, mem_we} !== {addr, (we ? st : 4'h0)}) begin
                errors++;
                $display("FAIL %s_port: addr=%0d we=%h required addr=%0d we=%h", tag, mem_addr, mem_we, addr, (we ? st : 4'h0));
            end
            if (we) begin
                checks++;
                if (mem_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s_wdata: got %h required %h", tag, mem_wdata, wd);
                end
                ref_mem[int'(addr)] = merge_bytes(ref_mem[int'(addr)], wd, st);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if ({host_ack, host_err, host_rdata} !== {1'b1, !in_rng, exp_rd}) begin
            errors++;
            $display("FAIL %s_ack: ack=%b err=%b rdata=%h required ack=1 err=%b rdata=%h", tag, host_ack, host_err, host_rdata, !in_rng, exp_rd);
        end
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_access_in_ack: mem_en=%b required 0", tag, mem_en);
        end
        rd = host_rdata;
        tick();
        host_req = 1'b0;
        @(negedge clk);
        checks++;
        if (host_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: host_ack=%b required 0", tag, host_ack);
        end
        tick();
    endtask

    // Host read behind continuous video requests; returns the read data.
    task automatic starved_read(input logic [ADDR_W-1:0] addr, input string tag,
                                output logic [31:0] rd);
        logic        vg_prev, vg_exp;
        logic [31:0] vd_prev;
        rd = 32'h0; vg_prev = 1'b0; vd_prev = 32'h0;
        host_req = 1'b1; host_we = 1'b0; host_addr = addr;
        host_wdata = '0; host_wstrb = 4'h0; vid_req = 1'b1;
        for (int k = 1; k <= STARVE_MAX + 2; k++) begin
            vid_addr = ADDR_W'($urandom_range(0, NUM_WORDS - 2));
            vg_exp   = (k != STARVE_MAX + 1);
            @(negedge clk);
            checks++;
            if (vid_gnt !== vg_exp) begin
                errors++;
                $display("FAIL %s_vid_gnt cycle %0d: got %b required %b", tag, k, vid_gnt, vg_exp);
            end
            if (k == STARVE_MAX + 1) begin
                checks++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, addr}) begin
                    errors++;
                    $display("FAIL %s_forced_slot: en=%b we=%h addr=%0d required en=1 we=0 addr=%0d", tag, mem_en, mem_we, mem_addr, addr);
                end
            end
            checks++;
            if (host_ack !== (k == STARVE_MAX + 2)) begin
                errors++;
                $display("FAIL %s_ack_timing cycle %0d: host_ack=%b required %b", tag, k, host_ack, (k == STARVE_MAX + 2));
            end
            if (k == STARVE_MAX + 2) begin
                rd = host_rdata;
                checks++;
                if (host_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_err: host_err=%b required 0", tag, host_err);
                end
            end
            if (k > 1) begin
                checks++;
                if (vid_rvalid !== vg_prev || (vg_prev && vid_rdata !== vd_prev)) begin
                    errors++;
                    $display("FAIL %s_vid_data cycle %0d: rvalid=%b rdata=%h required rvalid=%b rdata=%h", tag, k, vid_rvalid, vid_rdata, vg_prev, vd_prev);
                end
            end
            vg_prev = vg_exp;
            vd_prev = ref_mem[int'(vid_addr)];
            tick();
        end
        host_req = 1'b0; vid_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        host_wdata = '0; host_wstrb = 4'h0; vid_req = 1'b0; vid_addr = '0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({host_ack, host_err, vid_gnt, vid_rvalid, mem_en, mem_we} !== 9'h0) begin
            errors++;
            $display("FAIL reset_ctrl: ack/err/gnt/rvalid/en/we=%b%b%b%b%b%h required all 0", host_ack, host_err, vid_gnt, vid_rvalid, mem_en, mem_we);
        end
        checks++;
        if ({host_rdata, vid_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h vrdata=%h addr=%h wdata=%h required 0", host_rdata, vid_rdata, mem_addr, mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic [31:0] rd;
        host_single(1'b1, ADDR_W'(5), 32'hDEAD_BEEF, 4'hF, "single_write", rd);
        host_single(1'b0, ADDR_W'(5), 32'h0, 4'h0, "readback5", rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write_readback: got %h required deadbeef", rd);
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd;
        host_single(1'b1, ADDR_W'(7), 32'h1122_3344, 4'hF, "strobe_full", rd);
        host_single(1'b1, ADDR_W'(7), 32'hAABB_CCDD, 4'b0101, "strobe_part", rd);
        host_single(1'b1, ADDR_W'(7), 32'h5555_5555, 4'h0, "strobe_none", rd);
        host_single(1'b0, ADDR_W'(7), 32'h0, 4'h0, "readback7", rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL byte_strobe_readback: got %h required 11bb33dd", rd);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] rd;
        starved_read(ADDR_W'(600), "starve", rd);
        checks++;
        if (rd !== CTRL_INIT) begin
            errors++;
            $display("FAIL starve_rdata: got %h required %h", rd, CTRL_INIT);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        host_single(1'b0, ADDR_W'(601), 32'h0, 4'h0, "oor_read", rd);
        host_single(1'b1, ADDR_W'(1023), 32'hFFFF_FFFF, 4'hF, "oor_write", rd);
    endtask

    task automatic test_four_phase();
        int ack_cnt;
        host_req = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(3); vid_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL four_phase_first_grant: mem_en=%b required 1", mem_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({host_ack, host_rdata} !== {1'b1, ref_mem[3]}) begin
            errors++;
            $display("FAIL four_phase_first_ack: ack=%b rdata=%h required 1 %h", host_ack, host_rdata, ref_mem[3]);
        end
        ack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (host_ack === 1'b1 || mem_en === 1'b1) ack_cnt++;
        end
        checks++;
        if (ack_cnt !== 0) begin
            errors++;
            $display("FAIL four_phase_hold: %0d cycles with ack or mem_en, required 0", ack_cnt);
        end
        tick();
        host_req = 1'b0;
        tick();
        host_req = 1'b1; host_addr = ADDR_W'(5);
        @(negedge clk);
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, ADDR_W'(5)}) begin
            errors++;
            $display("FAIL four_phase_second_grant: en=%b addr=%0d required en=1 addr=5", mem_en, mem_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({host_ack, host_rdata} !== {1'b1, ref_mem[5]}) begin
            errors++;
            $display("FAIL four_phase_second_ack: ack=%b rdata=%h required 1 %h", host_ack, host_rdata, ref_mem[5]);
        end
        tick();
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_during_wait();
        logic [31:0] rd;
        host_req = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(10);
        vid_req = 1'b1; vid_addr = ADDR_W'(20);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({vid_gnt, host_ack} !== 2'b10) begin
                errors++;
                $display("FAIL rst_wait_pre cycle %0d: gnt=%b ack=%b required 1 0", k, vid_gnt, host_ack);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({host_ack, host_err, vid_gnt, vid_rvalid, mem_en, mem_we} !== 9'h0 ||
            {host_rdata, vid_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs: ack=%b gnt=%b rvalid=%b en=%b we=%h required all 0", host_ack, vid_gnt, vid_rvalid, mem_en, mem_we);
        end
        tick();
        rst_n = 1'b1; host_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (host_ack !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_no_ack cycle %0d: host_ack=%b required 0", k, host_ack);
            end
            tick();
        end
        // A full STARVE_MAX denials before the forced slot shows the counter restarted at 0.
        starved_read(ADDR_W'(10), "rst_wait_restart", rd);
        checks++;
        if (rd !== ref_mem[10]) begin
            errors++;
            $display("FAIL rst_wait_rdata: got %h required %h", rd, ref_mem[10]);
        end
    endtask

    task automatic test_random_traffic();
        logic        pend, ack_now, after_ack;
        int          hd;
        logic        h_we;
        logic [ADDR_W-1:0] h_addr;
        logic [31:0] h_wd;
        logic [3:0]  h_st;
        logic        h_in_rng;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        v_prev;
        logic [31:0] v_prev_data;
        logic        vg_exp, served, exp_en;
        pend = 1'b0; ack_now = 1'b0; after_ack = 1'b0; hd = 0;
        h_we = 1'b0; h_addr = '0; h_wd = '0; h_st = '0; h_in_rng = 1'b0;
        exp_err = 1'b0; exp_rd = '0; v_prev = 1'b0; v_prev_data = '0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (cyc >= 1500 && !pend && !ack_now && !after_ack) break;
            // Drive phase
            if (after_ack) begin
                host_req  = 1'b0;
                after_ack = 1'b0;
            end else if (!pend && !ack_now && cyc < 1500 && $urandom_range(0, 1) == 1) begin
                h_we     = 1'($urandom_range(0, 1));
                h_addr   = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(601, 1023))
                                                       : ADDR_W'($urandom_range(0, 600));
                h_wd     = $urandom;
                h_st     = 4'($urandom_range(0, 15));
                h_in_rng = int'(h_addr) < NUM_WORDS;
                host_req = 1'b1; host_we = h_we; host_addr = h_addr;
                host_wdata = h_wd; host_wstrb = h_st;
                pend = 1'b1; hd = 0;
            end
            vid_req  = ($urandom_range(0, 99) < 70);
            vid_addr = ADDR_W'($urandom_range(0, NUM_WORDS - 1));

            vg_exp = vid_req && !(pend && hd == STARVE_MAX);
            served = pend && !vg_exp;
            exp_en = vg_exp || (served && h_in_rng);

            @(negedge clk);
            checks++;
            if ({vid_gnt, mem_en} !== {vg_exp, exp_en}) begin
                errors++;
                $display("FAIL rand_grant cyc %0d: gnt=%b en=%b required gnt=%b en=%b", cyc, vid_gnt, mem_en, vg_exp, exp_en);
            end
            if (vg_exp) begin
                checks++;
                if ({mem_addr, mem_we} !== {vid_addr, 4'h0}) begin
                    errors++;
                    $display("FAIL rand_vid_port cyc %0d: addr=%0d we=%h required addr=%0d we=0", cyc, mem_addr, mem_we, vid_addr);
                end
            end else if (served && h_in_rng) begin
                checks++;
                if ({mem_addr, mem_we} !== {h_addr, (h_we ? h_st : 4'h0)} ||
                    (h_we && mem_wdata !== h_wd)) begin
                    errors++;
                    $display("FAIL rand_host_port cyc %0d: addr=%0d we=%h wdata=%h required addr=%0d we=%h wdata=%h", cyc, mem_addr, mem_we, mem_wdata, h_addr, (h_we ? h_st : 4'h0), h_wd);
                end
            end
            checks++;
            if (host_ack !== ack_now) begin
                errors++;
                $display("FAIL rand_host_ack cyc %0d: got %b required %b", cyc, host_ack, ack_now);
            end
            if (ack_now) begin
                checks++;
                if ({host_err, host_rdata} !== {exp_err, exp_rd}) begin
                    errors++;
                    $display("FAIL rand_host_resp cyc %0d: err=%b rdata=%h required err=%b rdata=%h", cyc, host_err, host_rdata, exp_err, exp_rd);
                end
            end
            checks++;
            if (vid_rvalid !== v_prev || (v_prev && vid_rdata !== v_prev_data)) begin
                errors++;
                $display("FAIL rand_vid_resp cyc %0d: rvalid=%b rdata=%h required rvalid=%b rdata=%h", cyc, vid_rvalid, vid_rdata, v_prev, v_prev_data);
            end

            // Model update for this slot
            v_prev = vg_exp;
            if (vg_exp) v_prev_data = ref_mem[int'(vid_addr)];
            if (ack_now) begin
                ack_now   = 1'b0;
                after_ack = 1'b1;
            end
            if (served) begin
                pend    = 1'b0;
                ack_now = 1'b1;
                exp_err = !h_in_rng;
                exp_rd  = 32'h0;
                if (h_in_rng && !h_we) exp_rd = ref_mem[int'(h_addr)];
                if (h_in_rng && h_we) ref_mem[int'(h_addr)] = merge_bytes(ref_mem[int'(h_addr)], h_wd, h_st);
            end else if (pend) begin
                hd++;
            end
            tick();
        end
        host_req = 1'b0; vid_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            ref_mem[i] = (i == NUM_WORDS - 1) ? CTRL_INIT : $urandom;
            bram[i]    = ref_mem[i];
        end
        test_reset();
        test_single_write();
        test_byte_strobe();
        test_starvation();
        test_out_of_range();
        test_four_phase();
        test_reset_during_wait();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
